// File: rtl/mmio_gpio_responder.sv
// MMIO target for the CPU MEM stage: LED register, debounced button with sticky press event,
// and an optional free-running timer at 0x7D enabled by defining MMIO_TIMER_EN.
module mmio_gpio_responder #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LED_WIDTH       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic                 i_rd,
  input  logic                 i_wr,
  output logic [31:0]          o_rdata,
  output logic                 o_hit,
  input  logic                 i_button,
  output logic [LED_WIDTH-1:0] o_led
);

  localparam int              CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     ADDR_LED   = 32'h0000_007A;
  localparam logic [31:0]     ADDR_BTN   = 32'h0000_007B;
  localparam logic [31:0]     ADDR_EVT   = 32'h0000_007C;
  localparam logic [31:0]     ADDR_TIMER = 32'h0000_007D;

  logic [LED_WIDTH-1:0] r_led;
  logic                 r_sync0;
  logic                 r_sync1;
  logic                 r_stable;
  logic [CW-1:0]        r_cnt;
  logic                 r_event;
  logic [31:0]          w_rdata;
  logic                 w_in_range;
  logic                 w_cnt_done;
  logic                 w_press;
  logic                 w_clr_event;

  assign w_in_range  = (i_addr >= ADDR_LED) && (i_addr <= ADDR_TIMER);
  assign w_cnt_done  = (r_cnt == CNT_LAST);
  // Press is the edge where the debouncer accepts a low level while currently high.
  assign w_press     = r_stable & ~r_sync1 & w_cnt_done;
  assign w_clr_event = i_wr & (i_addr == ADDR_EVT) & i_wdata[0];

  assign o_hit   = (i_rd | i_wr) & w_in_range;
  assign o_rdata = w_rdata;
  assign o_led   = r_led;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= '1;
    end else if (i_wr && (i_addr == ADDR_LED)) begin
      r_led <= i_wdata[LED_WIDTH-1:0];
    end else begin
      r_led <= r_led;
    end
  end

  // Synchronizer and debouncer; any return to the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0  <= 1'b1;
      r_sync1  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync0 <= i_button;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_stable) begin
        r_cnt <= '0;
      end else if (w_cnt_done) begin
        r_stable <= r_sync1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_event <= 1'b0;
    end else if (w_press) begin
      r_event <= 1'b1;
    end else if (w_clr_event) begin
      r_event <= 1'b0;
    end else begin
      r_event <= r_event;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] r_timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= 32'h0000_0000;
    end else if (i_wr && (i_addr == ADDR_TIMER)) begin
      r_timer <= i_wdata;
    end else begin
      r_timer <= r_timer + 32'h0000_0001;
    end
  end
`else
  logic w_unused_wdata;
  assign w_unused_wdata = &{1'b0, i_wdata};
`endif

  always_comb begin
    w_rdata = 32'h0000_0000;
    if (i_rd) begin
      case (i_addr)
        ADDR_LED: w_rdata[LED_WIDTH-1:0] = r_led;
        ADDR_BTN: w_rdata[0] = ~r_stable;
        ADDR_EVT: w_rdata[0] = r_event;
`ifdef MMIO_TIMER_EN
        ADDR_TIMER: w_rdata = r_timer;
`else
        ADDR_TIMER: w_rdata = 32'h0000_0000;
`endif
        default: w_rdata = 32'h0000_0000;
      endcase
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mmio_gpio_responder.sv
// Directed bench for mmio_gpio_responder with a short debounce; covers MMIO_TIMER_EN either way.
module tb_mmio_gpio_responder;

  localparam int DB = 4;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   i_addr;
  logic [31:0]   i_wdata;
  logic          i_rd;
  logic          i_wr;
  logic [31:0]   o_rdata;
  logic          o_hit;
  logic          i_button;
  logic [LW-1:0] o_led;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          rd;
    logic          wr;
    logic [31:0]   exp_rdata;
    logic          exp_hit;
    logic [LW-1:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  mmio_gpio_responder #(.DEBOUNCE_CYCLES(DB), .LED_WIDTH(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .o_rdata  (o_rdata),
    .o_hit    (o_hit),
    .i_button (i_button),
    .o_led    (o_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_rd    = 1'b0;
    i_wr    = 1'b0;
    i_addr  = 32'h0000_0000;
    i_wdata = 32'h0000_0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    i_addr = a;
    i_rd   = 1'b1;
    i_wr   = 1'b0;
    #1;
    d    = o_rdata;
    i_rd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    i_addr  = a;
    i_wdata = wd;
    i_wr    = 1'b1;
    i_rd    = 1'b0;
    tick();
    idle();
  endtask

  function automatic void add(input logic [31:0] a, input logic [31:0] wd, input logic r,
                              input logic w, input logic [31:0] er, input logic eh,
                              input logic [LW-1:0] el);
    vec_t v;
    v.addr = a; v.wdata = wd; v.rd = r; v.wr = w;
    v.exp_rdata = er; v.exp_hit = eh; v.exp_led = el;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;

    add(32'h7A, 32'h0,        1'b1, 1'b0, 32'h3F, 1'b1, 6'h3F);
    add(32'h7B, 32'h0,        1'b1, 1'b0, 32'h00, 1'b1, 6'h3F);
    add(32'h7C, 32'h0,        1'b1, 1'b0, 32'h00, 1'b1, 6'h3F);
    add(32'h7A, 32'h0,        1'b0, 1'b0, 32'h00, 1'b0, 6'h3F);
    add(32'h7A, 32'h12345615, 1'b0, 1'b1, 32'h00, 1'b1, 6'h15);
    add(32'h80, 32'h0,        1'b0, 1'b1, 32'h00, 1'b0, 6'h15);
    add(32'h7A, 32'h0,        1'b1, 1'b0, 32'h15, 1'b1, 6'h15);
    add(32'h80, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00, 1'b0, 6'h15);
    add(32'h79, 32'h0,        1'b1, 1'b0, 32'h00, 1'b0, 6'h15);
    add(32'h17A, 32'h3F,      1'b0, 1'b1, 32'h00, 1'b0, 6'h15);
    add(32'h7B, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00, 1'b1, 6'h15);
    add(32'h7B, 32'h0,        1'b1, 1'b0, 32'h00, 1'b1, 6'h15);
    add(32'h7C, 32'h0,        1'b1, 1'b1, 32'h00, 1'b1, 6'h15);
`ifndef MMIO_TIMER_EN
    add(32'h7D, 32'h0,        1'b1, 1'b0, 32'h00, 1'b1, 6'h15);
    add(32'h7D, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00, 1'b1, 6'h15);
    add(32'h7D, 32'h0,        1'b1, 1'b0, 32'h00, 1'b1, 6'h15);
`endif
    add(32'h7A, 32'h3F,       1'b1, 1'b1, 32'h15, 1'b1, 6'h3F);
    add(32'h7A, 32'h0,        1'b1, 1'b1, 32'h3F, 1'b1, 6'h00);

    idle();
    i_button = 1'b1;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_led", 32'(o_led), 32'h3F);
    #1;
    chk("idle_hit", 32'(o_hit), 32'h0);

    foreach (vecs[i]) begin
      i_addr  = vecs[i].addr;
      i_wdata = vecs[i].wdata;
      i_rd    = vecs[i].rd;
      i_wr    = vecs[i].wr;
      #1;
      chk($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_hit", i), 32'(o_hit), 32'(vecs[i].exp_hit));
      tick();
      chk($sformatf("vec%0d_led", i), 32'(o_led), 32'(vecs[i].exp_led));
      idle();
    end

    // Clean press: visible exactly 2 + DB edges after the button first samples low.
    i_button = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(32'h7B, d);
      if (k == 5) chk("press_before", d, 32'h0);
      if (k == 6) chk("press_at", d, 32'h1);
    end
    rd(32'h7C, d);
    chk("press_event", d, 32'h1);

    wr(32'h7C, 32'h0);
    rd(32'h7C, d);
    chk("w1c_zero", d, 32'h1);
    wr(32'h7C, 32'h1);
    rd(32'h7C, d);
    chk("w1c_one", d, 32'h0);

    i_button = 1'b1;
    repeat (6) tick();
    rd(32'h7B, d);
    chk("release_btn", d, 32'h0);
    rd(32'h7C, d);
    chk("release_event", d, 32'h0);

    i_button = 1'b0;
    repeat (3) tick();
    i_button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      rd(32'h7B, d);
      chk($sformatf("glitch_btn%0d", k), d, 32'h0);
    end
    rd(32'h7C, d);
    chk("glitch_event", d, 32'h0);

    // Press lands on the same edge as a W1C write: set must win.
    i_button = 1'b0;
    repeat (5) tick();
    rd(32'h7B, d);
    chk("coinc_before", d, 32'h0);
    wr(32'h7C, 32'h1);
    rd(32'h7C, d);
    chk("coinc_event", d, 32'h1);
    rd(32'h7B, d);
    chk("coinc_btn", d, 32'h1);
    wr(32'h7C, 32'h1);
    rd(32'h7C, d);
    chk("coinc_clear", d, 32'h0);

    // Reset mid-release-debounce, then a fresh press must take the full latency.
    i_button = 1'b1;
    repeat (4) tick();
    rd(32'h7B, d);
    chk("middb_btn", d, 32'h1);
    reset    = 1'b1;
    i_button = 1'b0;
    tick();
    rd(32'h7B, d);
    chk("rst_btn", d, 32'h0);
    rd(32'h7C, d);
    chk("rst_event", d, 32'h0);
    chk("rst_led", 32'(o_led), 32'h3F);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(32'h7B, d);
      if (k == 5) chk("repress_before", d, 32'h0);
      if (k == 6) chk("repress_at", d, 32'h1);
    end

`ifdef MMIO_TIMER_EN
    wr(32'h7D, 32'hFFFFFFFE);
    tick();
    rd(32'h7D, d);
    chk("timer_max", d, 32'hFFFFFFFF);
    tick();
    rd(32'h7D, d);
    chk("timer_wrap", d, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
